// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time session controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitDelay,
        StStim,
        StCapture,
        StResult,
        StFalseStart,
        StSummary
    } state_t;

    localparam logic [13:0] MAX_MS    = 14'd9999;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois step for x^16+x^14+x^13+x^11+1; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit Galois LFSR; seed reloaded on reset, low bits exported.
module reaction_lfsr #(
    parameter int unsigned OUT_BITS = 11
) (
    input  logic                clk,
    input  logic                reset,
    output logic [OUT_BITS-1:0] rand_bits
);
    import reaction_pkg::*;

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign rand_bits = lfsr_q[OUT_BITS-1:0];

endmodule

// File: rtl/reaction_session_ctrl.sv
// Multi-round reaction-time session controller driving the ms timer and 7-seg display.
// Optional AVG_DISPLAY_EN: in SUMMARY, react_btn toggles the display between best and average.
module reaction_session_ctrl #(
    parameter int unsigned NUM_ROUNDS      = 4,
    parameter int unsigned MIN_DELAY_MS    = 1000,
    parameter int unsigned RAND_RANGE_BITS = 11,
    parameter int unsigned HOLD_MS         = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        react_btn,
    input  logic        tick_1ms,
    input  logic [13:0] ms_time,
    output logic        timer_clear,
    output logic        timer_start,
    output logic        timer_stop,
    output logic        stim_led,
    output logic [13:0] disp_value,
    output logic        show_error,
    output logic [3:0]  round_idx,
    output logic        session_done
);
    import reaction_pkg::*;

    localparam int unsigned HoldW = $clog2(HOLD_MS + 1);

    state_t               state_q, state_d;
    logic [15:0]          delay_q, delay_d;
    logic [13:0]          best_q, best_d;
    logic [13:0]          disp_q, disp_d;
    logic [4:0]           round_q, round_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic                 entry_q, entry_d;
    logic                 cap_q, cap_d;
    logic                 clr_q, clr_d, go_q, go_d, stop_q, stop_d;
    logic                 stim_q, stim_d, err_q, err_d, done_q, done_d;
    logic                 session_start;
    logic                 hold_done;
    logic [RAND_RANGE_BITS-1:0] rand_bits;

`ifdef AVG_DISPLAY_EN
    localparam int unsigned LogRounds = $clog2(NUM_ROUNDS);
    localparam int unsigned SumW      = 14 + LogRounds;

    logic [SumW-1:0] sum_q, sum_d;
    logic            avg_sel_q, avg_sel_d;
    logic [13:0]     avg;

    assign avg = 14'(sum_q >> LogRounds);
`endif

    reaction_lfsr #(
        .OUT_BITS (RAND_RANGE_BITS)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .rand_bits (rand_bits)
    );

    // The first in-state cycle never counts a tick, even if one arrives then.
    assign hold_done = tick_1ms && !entry_q && (hold_q == HoldW'(HOLD_MS - 1));

    always_comb begin
        state_d       = state_q;
        delay_d       = delay_q;
        best_d        = best_q;
        disp_d        = disp_q;
        round_d       = round_q;
        hold_d        = hold_q;
        entry_d       = entry_q;
        cap_d         = cap_q;
        clr_d         = 1'b0;
        go_d          = 1'b0;
        stop_d        = 1'b0;
        session_start = 1'b0;
`ifdef AVG_DISPLAY_EN
        sum_d         = sum_q;
        avg_sel_d     = avg_sel_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start_btn) session_start = 1'b1;
            end
            StArm: begin
                delay_d = 16'(MIN_DELAY_MS) + 16'(rand_bits);
                state_d = StWaitDelay;
            end
            StWaitDelay: begin
                if (react_btn) begin
                    state_d = StFalseStart;
                    hold_d  = '0;
                    entry_d = 1'b1;
                end else if (delay_q == 16'd0) begin
                    state_d = StStim;
                    clr_d   = 1'b1;
                    go_d    = 1'b1;
                end else if (tick_1ms) begin
                    delay_d = delay_q - 16'd1;
                end
            end
            StStim: begin
                if (react_btn || ms_time == MAX_MS) begin
                    stop_d  = 1'b1;
                    cap_d   = 1'b0;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // Second cycle: the timer has absorbed the stop pulse and holds the final count.
                if (!cap_q) begin
                    cap_d = 1'b1;
                end else begin
                    cap_d   = 1'b0;
                    disp_d  = ms_time;
                    if (ms_time < best_q) best_d = ms_time;
`ifdef AVG_DISPLAY_EN
                    sum_d   = sum_q + SumW'(ms_time);
`endif
                    state_d = StResult;
                    hold_d  = '0;
                    entry_d = 1'b1;
                end
            end
            StResult, StFalseStart: begin
                entry_d = 1'b0;
                if (tick_1ms && !entry_q) hold_d = hold_q + 1'b1;
                if (hold_done) begin
                    state_d = StArm;
                    if (state_q == StResult) begin
                        round_d = round_q + 5'd1;
                        if (round_q + 5'd1 == 5'(NUM_ROUNDS)) begin
                            state_d = StSummary;
                            disp_d  = best_q;
`ifdef AVG_DISPLAY_EN
                            avg_sel_d = 1'b0;
`endif
                        end
                    end
                end
            end
            StSummary: begin
                if (start_btn) begin
                    session_start = 1'b1;
`ifdef AVG_DISPLAY_EN
                end else if (react_btn) begin
                    avg_sel_d = !avg_sel_q;
                    disp_d    = avg_sel_q ? best_q : avg;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if (session_start) begin
            state_d = StArm;
            round_d = '0;
            best_d  = MAX_MS;
            clr_d   = 1'b1;
`ifdef AVG_DISPLAY_EN
            sum_d   = '0;
`endif
        end

        stim_d = (state_d == StStim);
        err_d  = (state_d == StFalseStart);
        done_d = (state_d == StSummary);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            delay_q <= '0;
            best_q  <= MAX_MS;
            disp_q  <= '0;
            round_q <= '0;
            hold_q  <= '0;
            entry_q <= 1'b0;
            cap_q   <= 1'b0;
            clr_q   <= 1'b0;
            go_q    <= 1'b0;
            stop_q  <= 1'b0;
            stim_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            best_q  <= best_d;
            disp_q  <= disp_d;
            round_q <= round_d;
            hold_q  <= hold_d;
            entry_q <= entry_d;
            cap_q   <= cap_d;
            clr_q   <= clr_d;
            go_q    <= go_d;
            stop_q  <= stop_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef AVG_DISPLAY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q     <= '0;
            avg_sel_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            avg_sel_q <= avg_sel_d;
        end
    end
`endif

    assign timer_clear  = clr_q;
    assign timer_start  = go_q;
    assign timer_stop   = stop_q;
    assign stim_led     = stim_q;
    assign show_error   = err_q;
    assign session_done = done_q;
    assign disp_value   = disp_q;
    assign round_idx    = round_q[3:0];

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Bench for reaction_session_ctrl: procedural session model, timer model, directed sessions.
module tb_reaction_session_ctrl;

    localparam int NR = 2;
    localparam int MD = 2;
    localparam int RB = 2;
    localparam int HM = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_btn = 1'b0;
    logic        react_btn = 1'b0;
    logic        tick_1ms = 1'b0;
    logic [13:0] ms_time;
    logic        timer_clear, timer_start, timer_stop, stim_led, show_error, session_done;
    logic [13:0] disp_value;
    logic [3:0]  round_idx;

    int checks = 0;
    int errors = 0;

    reaction_session_ctrl #(
        .NUM_ROUNDS      (NR),
        .MIN_DELAY_MS    (MD),
        .RAND_RANGE_BITS (RB),
        .HOLD_MS         (HM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_btn    (start_btn),
        .react_btn    (react_btn),
        .tick_1ms     (tick_1ms),
        .ms_time      (ms_time),
        .timer_clear  (timer_clear),
        .timer_start  (timer_start),
        .timer_stop   (timer_stop),
        .stim_led     (stim_led),
        .disp_value   (disp_value),
        .show_error   (show_error),
        .round_idx    (round_idx),
        .session_done (session_done)
    );

    always #5 clk = ~clk;

    // 1 ms tick every 4 clocks, changed just after the falling edge
    initial begin
        int cyc = 0;
        forever begin
            @(negedge clk);
            #1;
            tick_1ms = (cyc % 4 == 3);
            cyc++;
        end
    end

    // Timer model: the bench can load a count and freeze counting
    logic [13:0] tm_cnt;
    logic        tm_run;
    logic        tm_load = 1'b0;
    logic        tm_freeze = 1'b0;
    logic [13:0] tm_val = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tm_cnt <= '0;
            tm_run <= 1'b0;
        end else begin
            if (timer_stop) tm_run <= 1'b0;
            else if (timer_start) tm_run <= 1'b1;
            if (tm_load) tm_cnt <= tm_val;
            else if (timer_clear) tm_cnt <= '0;
            else if (tm_run && tick_1ms && !tm_freeze && tm_cnt < 14'd9999) tm_cnt <= tm_cnt + 14'd1;
        end
    end
    assign ms_time = tm_cnt;

    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    // Session model: expected outputs for the cycle following each rising edge
    logic e_clear, e_start, e_stop, e_stim, e_err, e_done;
    logic [13:0] e_disp;
    int  e_round;
    int  m_best, m_sum, m_round, m_delay, m_ticks;
    int  m_first_delay = -1;
    bit  m_abort, m_in_wait, m_avg_sel;

    task automatic step();
        @(posedge clk or posedge reset);
        if (reset) m_abort = 1'b1;
        e_clear = 1'b0;
        e_start = 1'b0;
        e_stop  = 1'b0;
    endtask

    task automatic hold_ticks();
        int  n = 0;
        bit  first = 1'b1;
        while (n < HM) begin
            step();
            if (m_abort) return;
            if (tick_1ms && !first) n++;
            first = 1'b0;
        end
    endtask

    task automatic new_session();
        m_round = 0;
        m_best  = 9999;
        m_sum   = 0;
        e_clear = 1'b1;
        e_done  = 1'b0;
        e_round = 0;
    endtask

    task automatic play_round();
        int result;
        step();
        if (m_abort) return;
        m_delay = MD + int'(m_lfsr[RB-1:0]);
        if (m_first_delay < 0) m_first_delay = m_delay;
        m_ticks   = 0;
        m_in_wait = 1'b1;
        forever begin
            step();
            if (m_abort) return;
            if (react_btn) begin
                m_in_wait = 1'b0;
                e_err = 1'b1;
                hold_ticks();
                if (m_abort) return;
                e_err = 1'b0;
                return;
            end
            if (m_ticks == m_delay) begin
                m_in_wait = 1'b0;
                e_clear = 1'b1;
                e_start = 1'b1;
                e_stim  = 1'b1;
                break;
            end
            if (tick_1ms) m_ticks++;
        end
        forever begin
            step();
            if (m_abort) return;
            if (react_btn || ms_time == 14'd9999) begin
                e_stop = 1'b1;
                e_stim = 1'b0;
                break;
            end
        end
        step();
        if (m_abort) return;
        step();
        if (m_abort) return;
        result = int'(ms_time);
        e_disp = 14'(result);
        if (result < m_best) m_best = result;
        m_sum += result;
        hold_ticks();
        if (m_abort) return;
        m_round++;
        e_round = m_round;
        if (m_round == NR) begin
            e_done    = 1'b1;
            e_disp    = 14'(m_best);
            m_avg_sel = 1'b0;
        end
    endtask

    task automatic run_model();
        forever begin
            do begin
                step();
                if (m_abort) return;
            end while (!start_btn);
            new_session();
            forever begin
                while (m_round < NR) begin
                    play_round();
                    if (m_abort) return;
                end
                forever begin
                    step();
                    if (m_abort) return;
                    if (start_btn) break;
`ifdef AVG_DISPLAY_EN
                    if (react_btn) begin
                        m_avg_sel = !m_avg_sel;
                        e_disp = m_avg_sel ? 14'(m_sum >> $clog2(NR)) : 14'(m_best);
                    end
`endif
                end
                new_session();
            end
        end
    endtask

    initial begin
        forever begin
            m_abort = 1'b0;
            m_in_wait = 1'b0;
            {e_clear, e_start, e_stop, e_stim, e_err, e_done} = '0;
            e_disp  = '0;
            e_round = 0;
            wait (reset == 1'b0);
            run_model();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if ({timer_clear, timer_start, timer_stop, stim_led, show_error, session_done} !==
                {e_clear, e_start, e_stop, e_stim, e_err, e_done} ||
                disp_value !== e_disp || int'(round_idx) != e_round) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t clr/sta/stp/led/err/done got %b want %b disp got %0d want %0d round got %0d want %0d",
                         $time, {timer_clear, timer_start, timer_stop, stim_led, show_error, session_done},
                         {e_clear, e_start, e_stop, e_stim, e_err, e_done}, disp_value, e_disp,
                         round_idx, e_round);
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        nedge();
        start_btn = 1'b0;
    endtask

    task automatic pulse_react();
        react_btn = 1'b1;
        nedge();
        react_btn = 1'b0;
    endtask

    function automatic bit sig_of(input int sel);
        case (sel)
            0: return stim_led;
            1: return session_done;
            2: return timer_stop;
            default: return !show_error;
        endcase
    endfunction

    task automatic wait_out(input string name, input int sel, input int max_cyc);
        int n = 0;
        while (!sig_of(sel) && n < max_cyc) begin
            nedge();
            n++;
        end
        checks++;
        if (!sig_of(sel)) begin
            errors++;
            $display("FAIL %s timeout got 0 want 1 within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic do_round(input int val);
        wait_out("stim_rise", 0, 300);
        tm_val    = 14'(val);
        tm_load   = 1'b1;
        tm_freeze = 1'b1;
        nedge();
        tm_load = 1'b0;
        pulse_react();
    endtask

    initial begin
        #2;
        check_lit("reset_disp", int'(disp_value), 0);
        check_lit("reset_outs", int'({timer_clear, timer_start, timer_stop, stim_led, show_error,
                                      session_done, round_idx}), 0);
        #10 reset = 1'b0;
        nedge();
        check_lit("lfsr_pin", int'(m_lfsr), 16'hE270);
        nedge();
        nedge();

        // Session 1: results 123 then 87
        pulse_start();
        check_lit("arm_clear", int'(timer_clear), 1);
        wait_out("stim_rise1", 0, 300);
        check_lit("first_delay", m_first_delay, 4);
        check_lit("stim_pulses", int'({timer_start, timer_clear}), 3);
        tm_val = 14'd123;
        tm_load = 1'b1;
        tm_freeze = 1'b1;
        nedge();
        tm_load = 1'b0;
        pulse_react();
        check_lit("stop_pulse", int'(timer_stop), 1);
        nedge();
        nedge();
        check_lit("result_123", int'(disp_value), 123);
        do_round(87);
        check_lit("round_after_1", int'(round_idx), 1);
        wait_out("done1", 1, 300);
        check_lit("best_87", int'(disp_value), 87);
        check_lit("round_end", int'(round_idx), 2);
`ifdef AVG_DISPLAY_EN
        pulse_react();
        check_lit("avg_105", int'(disp_value), 105);
        pulse_react();
        check_lit("avg_back_87", int'(disp_value), 87);
`else
        pulse_react();
        check_lit("react_ignored", int'(disp_value), 87);
`endif

        // Session 2: false start in delay, false start on expiry, then 100 and a timeout
        pulse_start();
        check_lit("done_drop", int'(session_done), 0);
        nedge();
        pulse_react();
        check_lit("fs_error", int'(show_error), 1);
        wait_out("fs_clear", 3, 200);
        check_lit("fs_round", int'(round_idx), 0);
        begin
            int n = 0;
            while (!(m_in_wait && m_ticks == m_delay) && n < 200) begin
                nedge();
                n++;
            end
            check_lit("expiry_seen", int'(m_in_wait && m_ticks == m_delay), 1);
        end
        pulse_react();
        check_lit("fs_expiry_error", int'(show_error), 1);
        wait_out("fs2_clear", 3, 200);
        check_lit("fs2_round", int'(round_idx), 0);
        do_round(100);
        wait_out("stim_rise_to", 0, 300);
        tm_val = 14'd9997;
        tm_load = 1'b1;
        tm_freeze = 1'b0;
        nedge();
        tm_load = 1'b0;
        wait_out("timeout_stop", 2, 100);
        nedge();
        nedge();
        check_lit("timeout_9999", int'(disp_value), 9999);
        wait_out("done2", 1, 300);
        check_lit("best_kept_100", int'(disp_value), 100);

        // Session 3: 100 and 50
        pulse_start();
        do_round(100);
        do_round(50);
        wait_out("done3", 1, 300);
        check_lit("best_50", int'(disp_value), 50);
`ifdef AVG_DISPLAY_EN
        pulse_react();
        check_lit("avg_75", int'(disp_value), 75);
`endif

        // Session 4: reset during STIM
        pulse_start();
        wait_out("stim_rise_rst", 0, 300);
        reset = 1'b1;
        #1;
        check_lit("rst_outs", int'({timer_clear, timer_start, timer_stop, stim_led, show_error,
                                    session_done, round_idx}), 0);
        check_lit("rst_disp", int'(disp_value), 0);
        nedge();
        nedge();
        reset = 1'b0;
        nedge();

        // Session 5: best must restart from 9999
        pulse_start();
        do_round(5000);
        do_round(6000);
        wait_out("done5", 1, 300);
        check_lit("best_5000", int'(disp_value), 5000);

        nedge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
